prio_rr_arbiter: RTL and testbench
==================================

Name: prio_rr_arbiter

Overview:
- 8-channel priority arbiter with a registered output stage. It shares one downstream valid/ready sink between N_CH requesters, each carrying data plus a priority tag.
- Sits in front of the single output channel of the multi-channel top, and sequences which input channel's beat is forwarded each cycle.
- Highest priority wins; ties among equal priority are broken round-robin.

Parameters:
- N_CH, 8, number of input channels (power of 2, >= 2)
- DATA_W, 32, data width per channel
- PRIO_W, 3, priority tag width; larger value = more urgent
- AGE_MAX, 15, wait-cycle threshold for aging (used only with the optional feature)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- valid_i  input  N_CH  per-channel request valid
- data_i  input  N_CH*DATA_W  channel k data at bits [k*DATA_W +: DATA_W]
- prio_i  input  N_CH*PRIO_W  channel k priority at bits [k*PRIO_W +: PRIO_W]
- ready_i  output  N_CH  per-channel accept (combinational, one-hot or zero)
- valid_o  output  1  output beat valid (registered)
- data_o  output  DATA_W  output data (registered)
- src_o  output  log2(N_CH)  index of the channel that sourced the current output beat (registered)
- ready_o  input  1  downstream accept

Behaviour:
- Reset (clk edge with reset=1): valid_o=0, data_o=0, src_o=0, rr_ptr=0, all age counters=0. ready_i is 0 while reset=1.
- Slot free: out_free = ~valid_o | ready_o.
- Winner selection (combinational):
  - Among channels with valid_i=1, take the max effective priority.
  - Among channels at that priority, pick the first index found searching upward from rr_ptr, wrapping N_CH-1 -> 0.
- ready_i[w] = out_free for the winner w; all other ready_i bits = 0. No winner means ready_i = 0.
- A transfer occurs when valid_i[w] & ready_i[w]. On that edge:
  - data_o <= data_i[w], src_o <= w, valid_o <= 1.
  - rr_ptr <= (w+1) mod N_CH.
- If ready_o=1 with no new transfer: valid_o <= 0. data_o and src_o hold.
- If ready_o=0 and valid_o=1: output holds stable and ready_i = 0 (backpressure).
- Latency: 1 cycle from input accept to valid_o. Throughput: 1 beat/cycle when ready_o stays high.
- rr_ptr changes only on a transfer. With no valid inputs, or under backpressure, rr_ptr holds.
- A single active channel is granted every cycle regardless of rr_ptr.
- Inputs obey valid/ready: a requester holds data and prio until accepted. The arbiter may re-select each cycle, so grant is not sticky.
- Simultaneous downstream pop and new accept in the same cycle: the output register is overwritten with the new beat and valid_o stays 1.
- Reset mid-operation: an in-flight output beat is dropped and valid_o=0 next cycle.

Optional Feature:
- Macro: PRIO_RR_ARB_AGING_EN.
- Defined:
  - Per-channel age counter, width clog2(AGE_MAX+1), saturating at AGE_MAX.
  - Increments each cycle the channel has valid_i=1 and no transfer. Clears to 0 on its transfer or when valid_i=0.
  - At age == AGE_MAX, effective priority = all-ones (max). Otherwise effective priority = prio_i.
  - Aged channels then tie-break round-robin like any other equal-priority group.
- Undefined: no counters; effective priority = prio_i. Starvation of low priority under sustained high-priority load is permitted.

Test Plan:
- Reset: hold reset=1 for 3 cycles with all valid_i=1 -> ready_i=0, valid_o=0, data_o=0, src_o=0; the first grant after release goes to ch0 when all priorities are equal.
- Priority: ch2 prio=5 data=0xA2, ch6 prio=7 data=0xA6, ready_o=1 -> ready_i=0x40; next cycle data_o=0xA6, src_o=6. Then ch2 is granted and data_o=0xA2 one cycle later.
- Round-robin: all 8 channels valid, prio=3, ready_o=1, continuously -> src_o sequence 0,1,2,...,7,0, one beat per cycle, no bubbles.
- Backpressure: beat from ch1 (0x11) in output with ready_o=0 for 4 cycles, ch4 valid -> data_o holds 0x11, ready_i=0. ready_o=1 -> same cycle ready_i=0x10; next cycle data_o=ch4 data, src_o=4.
- Simultaneous pop and push: valid_o=1, ready_o=1, ch3 valid -> valid_o stays 1 and data_o updates to ch3 data with no idle cycle. rr_ptr=4 afterwards.
- Aging (macro defined, AGE_MAX=15): ch0 prio=7 always valid, ch5 prio=0 valid, ready_o=1 -> ch5 granted on the cycle after its age reaches 15 (first grant ~cycle 16). Without the macro, ch5 is never granted.

Source files
------------

// File: rtl/prio_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// prio_rr_arbiter_if
//
// Bundle of the request side (N_CH valid/data/priority requesters with a
// one-hot accept) and the single downstream valid/ready beat channel of the
// priority round-robin arbiter.
//
//   valid_i  [N_CH]            per-channel request valid
//   data_i   [N_CH*DATA_W]     channel k data at [k*DATA_W +: DATA_W]
//   prio_i   [N_CH*PRIO_W]     channel k priority at [k*PRIO_W +: PRIO_W]
//   ready_i  [N_CH]            per-channel accept, one-hot or zero
//   valid_o                    output beat valid
//   data_o   [DATA_W]          output beat data
//   src_o    [log2(N_CH)]      channel that sourced the output beat
//   ready_o                    downstream accept
//
// Modports: slave = the arbiter, master = requesters plus downstream sink.
// ---------------------------------------------------------------------------
interface prio_rr_arbiter_if #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 32,
  parameter int PRIO_W = 3
);
  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0]        valid_i;
  logic [N_CH*DATA_W-1:0] data_i;
  logic [N_CH*PRIO_W-1:0] prio_i;
  logic [N_CH-1:0]        ready_i;
  logic                   valid_o;
  logic [DATA_W-1:0]      data_o;
  logic [IDX_W-1:0]       src_o;
  logic                   ready_o;

  modport slave (
    input  valid_i, data_i, prio_i, ready_o,
    output ready_i, valid_o, data_o, src_o
  );

  modport master (
    output valid_i, data_i, prio_i, ready_o,
    input  ready_i, valid_o, data_o, src_o
  );
endinterface

// File: rtl/prio_rr_arbiter.sv
// ---------------------------------------------------------------------------
// prio_rr_arbiter
//
// N_CH-channel priority arbiter with a registered output stage. The highest
// effective priority among valid requesters wins; ties are broken by a
// round-robin search upward from rr_ptr. The winner's beat is captured into
// the output register whenever that register is empty or being popped.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    prio_rr_arbiter_if.slave (requesters + downstream channel)
//
// Optional feature (macro PRIO_RR_ARB_AGING_EN): per-channel wait counters
// saturating at AGE_MAX; a channel that has waited AGE_MAX cycles is promoted
// to the all-ones priority so low-priority traffic cannot starve.
// ---------------------------------------------------------------------------
module prio_rr_arbiter #(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 32,
  parameter int PRIO_W  = 3,
  parameter int AGE_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  prio_rr_arbiter_if.slave      bus
);

  localparam int IDX_W = $clog2(N_CH);

  // Reject configurations the round-robin wrap and age counter rely on.
  if (N_CH < 2 || (N_CH & (N_CH - 1)) != 0 || AGE_MAX < 1) begin : g_bad_cfg
    $error("prio_rr_arbiter: N_CH must be a power of 2 >= 2 and AGE_MAX >= 1");
  end

  logic [PRIO_W-1:0] eff_prio [N_CH];
  logic [PRIO_W-1:0] max_prio;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  cand;
  logic              found;
  logic              out_free;
  logic              xfer;

  // -------------------------------------------------------------------------
  // Effective priority
  // -------------------------------------------------------------------------
`ifdef PRIO_RR_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [AGE_W-1:0] age [N_CH];

  // NOTE: the age counters are state the arbitration depends on, so every
  // entry is explicitly reset; unlike a data RAM they must start at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) age[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (!bus.valid_i[k] || (xfer && win == IDX_W'(k)))
          age[k] <= '0;
        else if (age[k] != AGE_W'(AGE_MAX))
          age[k] <= age[k] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      eff_prio[k] = (age[k] == AGE_W'(AGE_MAX)) ? '1
                                                : bus.prio_i[k*PRIO_W +: PRIO_W];
    end
  end
`else
  always_comb begin
    for (int k = 0; k < N_CH; k++) eff_prio[k] = bus.prio_i[k*PRIO_W +: PRIO_W];
  end
`endif

  // -------------------------------------------------------------------------
  // Winner selection: max priority first, then round-robin from rr_ptr
  // -------------------------------------------------------------------------
  always_comb begin
    max_prio = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.valid_i[k] && eff_prio[k] > max_prio) max_prio = eff_prio[k];
    end
  end

  // NOTE: every variable written here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_CH; k++) begin
      // N_CH is a power of two, so the IDX_W-bit add wraps N_CH-1 -> 0.
      cand = rr_ptr + IDX_W'(k);
      if (!found && bus.valid_i[cand] && eff_prio[cand] == max_prio) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Slot is free when empty or being popped in this same cycle.
  assign out_free    = ~bus.valid_o | bus.ready_o;
  assign xfer        = found & out_free & ~reset;
  assign bus.ready_i = xfer ? ({{(N_CH-1){1'b0}}, 1'b1} << win) : '0;

  // -------------------------------------------------------------------------
  // Output register and round-robin pointer
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      bus.src_o   <= '0;
      rr_ptr      <= '0;
    end else if (xfer) begin
      // Covers the simultaneous pop + push case: overwrite, valid stays 1.
      bus.valid_o <= 1'b1;
      bus.data_o  <= bus.data_i[win*DATA_W +: DATA_W];
      bus.src_o   <= win;
      rr_ptr      <= win + 1'b1;
    end else if (bus.ready_o) begin
      bus.valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prio_rr_arbiter
//
// Directed self-checking bench for prio_rr_arbiter. Inputs change and
// outputs are sampled 1-2 time units after a rising edge, away from it.
// Expected values are hand-computed constants. The aging step expects a
// ch5 grant only when PRIO_RR_ARB_AGING_EN is defined.
// ---------------------------------------------------------------------------
module tb_prio_rr_arbiter;

  localparam int N_CH   = 8;
  localparam int DATA_W = 32;
  localparam int PRIO_W = 3;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  prio_rr_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W), .PRIO_W(PRIO_W)) bus ();

  prio_rr_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .PRIO_W(PRIO_W), .AGE_MAX(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic [PRIO_W-1:0] p,
                        input logic [DATA_W-1:0] d);
    bus.valid_i[k]                   = v;
    bus.prio_i[k*PRIO_W +: PRIO_W]   = p;
    bus.data_i[k*DATA_W +: DATA_W]   = d;
  endtask

  task automatic clear_all();
    bus.valid_i = '0;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [DATA_W-1:0] d, input logic [2:0] s);
    check({tag, ".valid_o"}, 64'(bus.valid_o), 64'(v));
    check({tag, ".data_o"},  64'(bus.data_o),  64'(d));
    check({tag, ".src_o"},   64'(bus.src_o),   64'(s));
  endtask

  initial begin
    logic [7:0] exp_rdy;
    total = 0;
    bad   = 0;
    bus.valid_i = '0;
    bus.data_i  = '0;
    bus.prio_i  = '0;
    bus.ready_o = 1'b1;
    reset       = 1'b1;

    // ---- Reset with every channel requesting at equal priority ----------
    for (int k = 0; k < N_CH; k++) set_ch(k, 1'b1, 3'd3, 32'hD0 + 32'(k));
    repeat (3) tick();
    #1;
    check("rst.ready_i", 64'(bus.ready_i), 64'h00);
    check_out("rst", 1'b0, 32'h0, 3'd0);

    // ---- Release: ch0 first, then strict round-robin with no bubbles -----
    reset = 1'b0;
    #1;
    check("rr0.ready_i", 64'(bus.ready_i), 64'h01);
    tick();
    check_out("rr0", 1'b1, 32'hD0, 3'd0);
    for (int k = 1; k <= N_CH; k++) begin
      #1;
      exp_rdy = 8'h01 << (k % N_CH);
      check($sformatf("rr%0d.ready_i", k), 64'(bus.ready_i), 64'(exp_rdy));
      tick();
      check_out($sformatf("rr%0d", k), 1'b1, 32'hD0 + 32'(k % N_CH), 3'(k % N_CH));
    end

    // ---- Idle pop: no requests, ready_o=1 drains the output --------------
    clear_all();
    tick();
    check("idle.valid_o", 64'(bus.valid_o), 64'h0);

    // ---- Priority: ch6 (7) beats ch2 (5); ch2 follows --------------------
    set_ch(2, 1'b1, 3'd5, 32'hA2);
    set_ch(6, 1'b1, 3'd7, 32'hA6);
    #1;
    check("prio.ready_i_a", 64'(bus.ready_i), 64'h40);
    tick();
    check_out("prio_a", 1'b1, 32'hA6, 3'd6);
    set_ch(6, 1'b0, 3'd7, 32'hA6);
    #1;
    check("prio.ready_i_b", 64'(bus.ready_i), 64'h04);
    tick();
    check_out("prio_b", 1'b1, 32'hA2, 3'd2);
    set_ch(2, 1'b0, 3'd5, 32'hA2);

    // ---- Backpressure: ch1 beat held 4 cycles while ch4 waits ------------
    set_ch(1, 1'b1, 3'd0, 32'h11);
    #1;
    check("bp.ready_i_load", 64'(bus.ready_i), 64'h02);
    tick();
    check_out("bp_load", 1'b1, 32'h11, 3'd1);
    set_ch(1, 1'b0, 3'd0, 32'h11);
    set_ch(4, 1'b1, 3'd0, 32'h44);
    bus.ready_o = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("bp%0d.ready_i", c), 64'(bus.ready_i), 64'h00);
      tick();
      check_out($sformatf("bp%0d", c), 1'b1, 32'h11, 3'd1);
    end
    bus.ready_o = 1'b1;
    #1;
    check("bp.ready_i_rel", 64'(bus.ready_i), 64'h10);
    tick();
    check_out("bp_rel", 1'b1, 32'h44, 3'd4);
    set_ch(4, 1'b0, 3'd0, 32'h44);

    // ---- Simultaneous pop and push: ch3 replaces ch4 beat, no idle -------
    set_ch(3, 1'b1, 3'd2, 32'h33);
    #1;
    check("pp.ready_i", 64'(bus.ready_i), 64'h08);
    tick();
    check_out("pp", 1'b1, 32'h33, 3'd3);
    // rr_ptr must now be 4: with ch3 and ch5 tied, the search from 4 hits ch5.
    set_ch(5, 1'b1, 3'd2, 32'h55);
    #1;
    check("pp.rr_ptr4", 64'(bus.ready_i), 64'h20);
    tick();
    check_out("pp_next", 1'b1, 32'h55, 3'd5);

    // ---- Reset mid-operation drops the in-flight beat, rr_ptr -> 0 -------
    bus.ready_o = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst.ready_i", 64'(bus.ready_i), 64'h00);
    tick();
    check_out("mid_rst", 1'b0, 32'h0, 3'd0);
    reset = 1'b0;
    bus.ready_o = 1'b1;
    #1;
    check("mid_rst.rr_ptr0", 64'(bus.ready_i), 64'h08);

    // ---- Aging: ch0 prio 7 always valid vs ch5 prio 0 --------------------
    clear_all();
    set_ch(0, 1'b1, 3'd7, 32'hB0);
    set_ch(5, 1'b1, 3'd0, 32'hB5);
    for (int j = 1; j <= 20; j++) begin
      #1;
`ifdef PRIO_RR_ARB_AGING_EN
      // ch5 reaches age 15 after edge 15 and wins the tie (rr_ptr=1) at edge 16.
      exp_rdy = (j == 16) ? 8'h20 : 8'h01;
`else
      exp_rdy = 8'h01;
`endif
      check($sformatf("age%0d.ready_i", j), 64'(bus.ready_i), 64'(exp_rdy));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
